// File: rtl/vrf_addr_gen_pkg.sv
// vrf_addr_pkg: shared types and helpers for the per-lane VRF address generator.
//   sew_e   : element width encoding (8/16/32 bit, 11 illegal)
//   dir_e   : traversal direction (1 = ascending, 0 = descending)
//   state_e : controller states
//   epr()   : elements held by one vector register in one lane for a given SEW
package vrf_addr_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Elements per register: each 32-bit row holds 4/2/1 elements at SEW 8/16/32.
  // The illegal encoding falls back to one element per row so that derived
  // limits never underflow; the controller never walks with it.
  function automatic int unsigned epr(input logic [1:0] sew, input int unsigned vloc);
    int unsigned n;
    case (sew)
      2'b00:   n = vloc << 2;
      2'b01:   n = vloc << 1;
      2'b10:   n = vloc;
      default: n = vloc;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vrf_addr_gen_if.sv
// vrf_addr_gen_if: address stream from the generator toward the lane VRF port.
//   valid_o    : payload valid (driven by master)
//   ready_i    : downstream accept (driven by slave)
//   addr_o     : VRF row address
//   byte_sel_o : byte offset of the element inside the row
//   last_o     : final beat of the operation
interface vrf_addr_gen_if #(
  parameter int AW = 9
);
  logic          valid_o;
  logic          ready_i;
  logic [AW-1:0] addr_o;
  logic [1:0]    byte_sel_o;
  logic          last_o;

  modport master (
    output valid_o, addr_o, byte_sel_o, last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, addr_o, byte_sel_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/vrf_addr_gen_elem_cnt.sv
// vrf_elem_cnt: register/element index counter for walking a register group.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load         : start a new walk (up: r=0,e=0; down: r=lmul,e=EPR-1)
//   advance      : step to the next element in direction dir
//   dir, sew     : traversal direction and element width in effect
//   lmul         : group size minus 1 (used on load only)
//   r, e         : index of the beat being prepared this cycle; equals the
//                  stored position unless load/advance is active, so the
//                  caller can register a payload in the same cycle
module vrf_elem_cnt
  import vrf_addr_pkg::*;
#(
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int MAX_LMUL          = 8,
  parameter int LW                = $clog2(MAX_LMUL),
  parameter int EW                = $clog2(VREG_LOC_PER_LANE * 4)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load,
  input  logic          advance,
  input  logic          dir,
  input  logic [1:0]    sew,
  input  logic [LW-1:0] lmul,
  output logic [LW-1:0] r,
  output logic [EW-1:0] e
);

  logic [LW-1:0] r_r;
  logic [EW-1:0] e_r;
  logic [EW-1:0] e_max_s;

  assign e_max_s = EW'(epr(sew, VREG_LOC_PER_LANE) - 32'd1);

  // Next index: load has priority, then a single step with row wrap.
  always_comb begin
    r = r_r;
    e = e_r;
    if (load) begin
      if (dir == DIR_UP) begin
        r = {LW{1'b0}};
        e = {EW{1'b0}};
      end else begin
        r = lmul;
        e = e_max_s;
      end
    end else if (advance) begin
      if (dir == DIR_UP) begin
        if (e_r == e_max_s) begin
          e = {EW{1'b0}};
          r = r_r + LW'(1);
        end else begin
          e = e_r + EW'(1);
          r = r_r;
        end
      end else begin
        if (e_r == {EW{1'b0}}) begin
          e = e_max_s;
          r = r_r - LW'(1);
        end else begin
          e = e_r - EW'(1);
          r = r_r;
        end
      end
    end else begin
      r = r_r;
      e = e_r;
    end
  end

  // Position register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_r <= {LW{1'b0}};
      e_r <= {EW{1'b0}};
    end else begin
      r_r <= r;
      e_r <= e;
    end
  end

endmodule

// File: rtl/vrf_addr_gen.sv
// vrf_addr_gen: per-lane VRF address generator.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : launch (sampled in IDLE only)
//   start_addr_i   : per-register base rows, register k at [k*AW +: AW]
//   lmul_i         : group size minus 1
//   sew_i          : 00=8b 01=16b 10=32b 11=illegal
//   dir_i          : 1=up, 0=down
//   slide_offset_i : row offset added to every address (low AW bits used)
//   el_count_i     : elements to emit (clipped to group capacity)
//   vrf_if         : valid/ready address stream (master side)
//   busy_o         : high while walking
//   done_o         : one-cycle completion pulse
//   err_o          : one-cycle pulse on illegal sew
module vrf_addr_gen
  import vrf_addr_pkg::*;
#(
  parameter int MEM_DEPTH         = 512,
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int VLANE_NUM         = 8,
  parameter int MAX_LMUL          = 8,
  parameter int AW                = $clog2(MEM_DEPTH),
  parameter int LW                = $clog2(MAX_LMUL),
  parameter int CNT_W             = $clog2(MAX_LMUL * VREG_LOC_PER_LANE * 4) + 1,
  parameter int SW                = 32 - $clog2(VLANE_NUM * 4),
  parameter int EW                = $clog2(VREG_LOC_PER_LANE * 4)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [MAX_LMUL*AW-1:0] start_addr_i,
  input  logic [LW-1:0]          lmul_i,
  input  logic [1:0]             sew_i,
  input  logic                   dir_i,
  input  logic [SW-1:0]          slide_offset_i,
  input  logic [CNT_W-1:0]       el_count_i,
  vrf_addr_gen_if.master         vrf_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]             state_r;
  logic [MAX_LMUL*AW-1:0] start_addr_r;
  logic [LW-1:0]          lmul_r;
  logic [1:0]             sew_r;
  logic                   dir_r;
  logic [AW-1:0]          slide_r;
  logic [CNT_W-1:0]       limit_r;
  logic [CNT_W-1:0]       emit_r;
  logic                   valid_r;
  logic [AW-1:0]          addr_r;
  logic [1:0]             byte_sel_r;
  logic                   last_r;
  logic                   done_r;
  logic                   err_r;

  logic                   ld_s;
  logic                   xfer_s;
  logic                   adv_s;
  logic [CNT_W-1:0]       cap_s;
  logic [CNT_W-1:0]       lim_s;
  logic [CNT_W-1:0]       lim_cur_s;
  logic [CNT_W-1:0]       emit_nxt_s;
  logic                   last_nxt_s;
  logic [MAX_LMUL*AW-1:0] cfg_start_addr_s;
  logic [LW-1:0]          cfg_lmul_s;
  logic [1:0]             cfg_sew_s;
  logic                   cfg_dir_s;
  logic [AW-1:0]          cfg_slide_s;
  logic [AW-1:0]          base_arr_s [MAX_LMUL];
  logic [LW-1:0]          r_s;
  logic [EW-1:0]          e_s;
  logic [AW-1:0]          row_off_s;
  logic [AW-1:0]          addr_nxt_s;
  logic [1:0]             bsel_nxt_s;
  logic                   unused_slide_s;

  // Upper slide bits address other lanes' rows and do not affect this lane.
  assign unused_slide_s = ^slide_offset_i[SW-1:AW];

  assign ld_s   = (state_r == ST_IDLE) && start_i && (sew_i != SEW_ILL)
                  && (el_count_i != CNT_W'(0));
  assign xfer_s = (state_r == ST_RUN) && valid_r && vrf_if.ready_i;
  assign adv_s  = xfer_s && !last_r;

  // On launch the live inputs steer the first beat; afterwards the latched copy.
  assign cfg_start_addr_s = ld_s ? start_addr_i                : start_addr_r;
  assign cfg_lmul_s       = ld_s ? lmul_i                      : lmul_r;
  assign cfg_sew_s        = ld_s ? sew_i                       : sew_r;
  assign cfg_dir_s        = ld_s ? dir_i                       : dir_r;
  assign cfg_slide_s      = ld_s ? slide_offset_i[AW-1:0]      : slide_r;

  // Element limit: requested count clipped to the group capacity.
  always_comb begin
    cap_s = CNT_W'((32'(lmul_i) + 32'd1) * epr(sew_i, VREG_LOC_PER_LANE));
    if (el_count_i < cap_s) begin
      lim_s = el_count_i;
    end else begin
      lim_s = cap_s;
    end
    lim_cur_s = ld_s ? lim_s : limit_r;
  end

  // Emitted-beat count for the beat being prepared and its last flag.
  always_comb begin
    if (ld_s) begin
      emit_nxt_s = CNT_W'(0);
    end else if (adv_s) begin
      emit_nxt_s = emit_r + CNT_W'(1);
    end else begin
      emit_nxt_s = emit_r;
    end
    last_nxt_s = (emit_nxt_s == (lim_cur_s - CNT_W'(1)));
  end

  // Unpack the per-register base rows.
  always_comb begin
    for (int k = 0; k < MAX_LMUL; k++) begin
      base_arr_s[k] = cfg_start_addr_s[k*AW +: AW];
    end
  end

  vrf_elem_cnt #(
    .VREG_LOC_PER_LANE (VREG_LOC_PER_LANE),
    .MAX_LMUL          (MAX_LMUL),
    .LW                (LW),
    .EW                (EW)
  ) u_elem_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (ld_s),
    .advance (adv_s),
    .dir     (cfg_dir_s),
    .sew     (cfg_sew_s),
    .lmul    (cfg_lmul_s),
    .r       (r_s),
    .e       (e_s)
  );

  // Row within the register and byte lane of the element for the current SEW.
  always_comb begin
    row_off_s  = {AW{1'b0}};
    bsel_nxt_s = 2'b00;
    case (cfg_sew_s)
      SEW8: begin
        row_off_s  = AW'(e_s >> 2'd2);
        bsel_nxt_s = e_s[1:0];
      end
      SEW16: begin
        row_off_s  = AW'(e_s >> 2'd1);
        bsel_nxt_s = {e_s[0], 1'b0};
      end
      SEW32: begin
        row_off_s  = AW'(e_s);
        bsel_nxt_s = 2'b00;
      end
      default: begin
        row_off_s  = AW'(e_s);
        bsel_nxt_s = 2'b00;
      end
    endcase
  end

  // Sum wraps modulo MEM_DEPTH by truncation to AW bits.
  assign addr_nxt_s = base_arr_s[r_s] + row_off_s + cfg_slide_s;

  // Controller: launch decisions, completion and error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            if (sew_i == SEW_ILL) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else if (el_count_i == CNT_W'(0)) begin
              done_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              valid_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer_s && last_r) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Configuration snapshot taken at launch; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_addr_r <= {(MAX_LMUL*AW){1'b0}};
      lmul_r       <= {LW{1'b0}};
      sew_r        <= 2'b00;
      dir_r        <= 1'b0;
      slide_r      <= {AW{1'b0}};
      limit_r      <= {CNT_W{1'b0}};
    end else if (ld_s) begin
      start_addr_r <= start_addr_i;
      lmul_r       <= lmul_i;
      sew_r        <= sew_i;
      dir_r        <= dir_i;
      slide_r      <= slide_offset_i[AW-1:0];
      limit_r      <= lim_s;
    end
  end

  // Payload register: only moves on launch or accepted beat, so it holds under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      emit_r     <= {CNT_W{1'b0}};
      addr_r     <= {AW{1'b0}};
      byte_sel_r <= 2'b00;
      last_r     <= 1'b0;
    end else if (ld_s || adv_s) begin
      emit_r     <= emit_nxt_s;
      addr_r     <= addr_nxt_s;
      byte_sel_r <= bsel_nxt_s;
      last_r     <= last_nxt_s;
    end
  end

  assign vrf_if.valid_o    = valid_r;
  assign vrf_if.addr_o     = addr_r;
  assign vrf_if.byte_sel_o = byte_sel_r;
  assign vrf_if.last_o     = last_r;
  assign busy_o            = (state_r == ST_RUN);
  assign done_o            = done_r;
  assign err_o             = err_r;

endmodule

// File: tb/tb_vrf_addr_gen.sv
// tb_vrf_addr_gen: directed self-checking bench for vrf_addr_gen.
module tb_vrf_addr_gen;

  localparam int AW    = 9;
  localparam int LW    = 3;
  localparam int ML    = 8;
  localparam int CNT_W = 9;
  localparam int SW    = 27;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic [ML*AW-1:0]   start_addr_i;
  logic [LW-1:0]      lmul_i;
  logic [1:0]         sew_i;
  logic               dir_i;
  logic [SW-1:0]      slide_offset_i;
  logic [CNT_W-1:0]   el_count_i;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vrf_addr_gen_if #(.AW(AW)) bus ();

  vrf_addr_gen dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .lmul_i         (lmul_i),
    .sew_i          (sew_i),
    .dir_i          (dir_i),
    .slide_offset_i (slide_offset_i),
    .el_count_i     (el_count_i),
    .vrf_if         (bus),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ML*AW-1:0] bases(input int b0, input int b1);
    logic [ML*AW-1:0] v;
    v = '0;
    v[0 +: AW]  = AW'(b0);
    v[AW +: AW] = AW'(b1);
    return v;
  endfunction

  task automatic launch(input logic [ML*AW-1:0] sa, input int lmul, input int sew,
                        input int dir, input int slide, input int cnt);
    start_addr_i   = sa;
    lmul_i         = LW'(lmul);
    sew_i          = 2'(sew);
    dir_i          = 1'(dir);
    slide_offset_i = SW'(slide);
    el_count_i     = CNT_W'(cnt);
    start_i        = 1'b1;
    step();
    start_i        = 1'b0;
  endtask

  task automatic beat(input string tag, input int a, input int bs, input int last);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, ".addr"}, 32'(bus.addr_o), 32'(a));
    chk({tag, ".bsel"}, 32'(bus.byte_sel_o), 32'(bs));
    chk({tag, ".last"}, 32'(bus.last_o), 32'(last));
    chk({tag, ".busy"}, 32'(busy_o), 32'd1);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, ".end_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, ".end_done"}, 32'(done_o), 32'd1);
    chk({tag, ".end_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int a3 [6];
    a3 = '{10, 10, 10, 10, 11, 11};

    rst_i = 1'b1; start_i = 1'b0; bus.ready_i = 1'b1;
    start_addr_i = '0; lmul_i = '0; sew_i = 2'b00; dir_i = 1'b1;
    slide_offset_i = '0; el_count_i = '0;
    step(); step();
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.addr", 32'(bus.addr_o), 32'd0);
    chk("rst.last", 32'(bus.last_o), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    step();

    // 1: up, sew32, two registers at 0 and 64
    launch(bases(0, 64), 1, 2, 1, 0, 16);
    for (int i = 0; i < 16; i++) begin
      beat("t1", (i < 8) ? i : 56 + i, 0, (i == 15) ? 1 : 0);
      step();
    end
    finish_chk("t1");

    // 2: down, launched in the same cycle done_o is high
    launch(bases(0, 64), 1, 2, 0, 0, 16);
    for (int i = 0; i < 16; i++) begin
      beat("t2", (i < 8) ? 71 - i : 15 - i, 0, (i == 15) ? 1 : 0);
      step();
    end
    finish_chk("t2");
    step();
    chk("t2.done_pulse", 32'(done_o), 32'd0);

    // 3: sew8 sub-word walk
    launch(bases(10, 0), 0, 0, 1, 0, 6);
    for (int i = 0; i < 6; i++) begin
      beat("t3", a3[i], i % 4, (i == 5) ? 1 : 0);
      step();
    end
    finish_chk("t3");
    step();

    // 4: backpressure holds beat 2 for three cycles
    launch(bases(0, 64), 1, 2, 1, 0, 16);
    beat("t4", 0, 0, 0); step();
    beat("t4", 1, 0, 0);
    step();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("t4.hold", 2, 0, 0);
      step();
    end
    bus.ready_i = 1'b1;
    for (int i = 2; i < 16; i++) begin
      beat("t4", (i < 8) ? i : 56 + i, 0, (i == 15) ? 1 : 0);
      step();
    end
    finish_chk("t4");
    step();

    // 5: address wrap past MEM_DEPTH and count clipped to one register
    launch(bases(508, 0), 0, 2, 1, 6, 20);
    for (int i = 0; i < 8; i++) begin
      beat("t5", 2 + i, 0, (i == 7) ? 1 : 0);
      step();
    end
    finish_chk("t5");
    step();

    // 6a: zero count
    launch(bases(0, 64), 1, 2, 1, 0, 0);
    chk("t6a.valid", 32'(bus.valid_o), 32'd0);
    chk("t6a.done", 32'(done_o), 32'd1);
    chk("t6a.err", 32'(err_o), 32'd0);
    chk("t6a.busy", 32'(busy_o), 32'd0);
    step();
    chk("t6a.done_pulse", 32'(done_o), 32'd0);

    // 6b: illegal sew
    launch(bases(0, 64), 1, 3, 1, 0, 16);
    chk("t6b.valid", 32'(bus.valid_o), 32'd0);
    chk("t6b.err", 32'(err_o), 32'd1);
    chk("t6b.done", 32'(done_o), 32'd1);
    chk("t6b.busy", 32'(busy_o), 32'd0);
    step();
    chk("t6b.err_pulse", 32'(err_o), 32'd0);
    chk("t6b.done_pulse", 32'(done_o), 32'd0);

    // 6c: reset mid-run aborts without done_o
    launch(bases(0, 64), 1, 2, 1, 0, 16);
    beat("t6c", 0, 0, 0); step();
    beat("t6c", 1, 0, 0); step();
    beat("t6c", 2, 0, 0);
    rst_i = 1'b1;
    step();
    chk("t6c.valid", 32'(bus.valid_o), 32'd0);
    chk("t6c.done", 32'(done_o), 32'd0);
    chk("t6c.busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    step();
    chk("t6c.done_after", 32'(done_o), 32'd0);
    chk("t6c.valid_after", 32'(bus.valid_o), 32'd0);

    // 6d: start_i and config changes during RUN are ignored
    launch(bases(10, 0), 0, 0, 1, 0, 6);
    beat("t6d", a3[0], 0, 0); step();
    beat("t6d", a3[1], 1, 0);
    start_i = 1'b1; sew_i = 2'b10; dir_i = 1'b0; start_addr_i = bases(300, 200);
    slide_offset_i = SW'(5); el_count_i = CNT_W'(3); lmul_i = LW'(4);
    step();
    start_i = 1'b0;
    for (int i = 2; i < 6; i++) begin
      beat("t6d", a3[i], i % 4, (i == 5) ? 1 : 0);
      step();
    end
    finish_chk("t6d");
    step();
    chk("t6d.idle_valid", 32'(bus.valid_o), 32'd0);
    chk("t6d.idle_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vrf_addr_gen.md
Name: vrf_addr_gen

Overview:
Per-lane vector register file (VRF) address generator for the vector core control unit.
- Walks a register group of up to MAX_LMUL registers at SEW 8/16/32.
- Supports up (ascending) and down (descending) traversal, a slide offset applied to every address, and an element-count limit.
- Emits one address per accepted beat on a valid/ready stream toward the lane VRF read/write port.
- Reports sub-word byte position and last/done status.

Parameters:
- MEM_DEPTH, 512, VRF entries per lane; AW = $clog2(MEM_DEPTH).
- VREG_LOC_PER_LANE, 8, 32-bit VRF rows per vector register per lane.
- VLANE_NUM, 8, lane count; sizes slide_offset_i.
- MAX_LMUL, 8, maximum registers per group; LW = $clog2(MAX_LMUL).
- CNT_W, $clog2(MAX_LMUL*VREG_LOC_PER_LANE*4)+1, element-count width.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, launch; sampled only in IDLE.
- start_addr_i, in, MAX_LMUL*AW, per-register base rows; register k occupies bits [k*AW +: AW].
- lmul_i, in, LW, group size minus 1.
- sew_i, in, 2, 00=8b, 01=16b, 10=32b, 11=illegal.
- dir_i, in, 1, 1=up, 0=down.
- slide_offset_i, in, 32-$clog2(VLANE_NUM*4), row offset; low AW bits are used.
- el_count_i, in, CNT_W, elements to emit.
- ready_i, in, 1, downstream accept.
- valid_o, out, 1, addr_o/byte_sel_o/last_o valid.
- addr_o, out, AW, VRF row address.
- byte_sel_o, out, 2, byte offset of the element within the row.
- last_o, out, 1, final beat of the operation.
- busy_o, out, 1, high in RUN.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, one-cycle pulse on illegal sew.

Behaviour:
- Reset: state=IDLE; all outputs 0; internal counters 0. A reset mid-operation aborts RUN. No done_o is produced for the aborted operation.
- Start handling in IDLE: start_i latches all configuration inputs.
  - sew=11: no beats; err_o and done_o pulse at T+1; stay IDLE.
  - el_count_i=0: no beats; done_o pulses at T+1.
  - Otherwise: enter RUN. The first valid_o is at T+1; all outputs are registered.
- Elements per register: EPR = VREG_LOC_PER_LANE << (2-sew).
- Counters: register index r (LW bits) and element index e.
  - Up: r=0, e=0, both incrementing; e wraps EPR-1 -> 0 with r+1.
  - Down: r=lmul, e=EPR-1, both decrementing; e wraps 0 -> EPR-1 with r-1.
- Address: addr_o = base[r] + (e >> (2-sew)) + slide, truncated modulo MEM_DEPTH (wraps silently).
- byte_sel_o: sew0 -> e[1:0]; sew1 -> {e[0],1'b0}; sew2 -> 00.
- Beat handshake: a beat transfers when valid_o && ready_i. While ready_i=0, valid_o and all payload stay stable. Counters advance only on transfer.
- Termination: last_o is asserted on the beat where emitted == min(el_count, (lmul+1)*EPR) - 1.
  - On transfer of the last beat: valid_o=0 and done_o=1 the next cycle; state returns to IDLE.
  - el_count greater than group capacity is clipped to group capacity.
- start_i during RUN is ignored. Configuration inputs may change freely during RUN.
- Back-to-back: start_i in the same cycle done_o is high is accepted, because state is already IDLE.
- Throughput is one beat per cycle under continuous ready_i.

Decomposition:
- Package vrf_addr_pkg holds:
  - sew_e enum (SEW8, SEW16, SEW32, SEW_ILL);
  - dir_e enum;
  - state_e enum (IDLE, RUN);
  - function epr(sew, VREG_LOC_PER_LANE).
- Sub-module vrf_elem_cnt: the bidirectional r/e counter with the wrap rules above.
  - Inputs: load, advance, dir, sew, lmul.
  - Outputs: r, e.
- The top level holds the FSM, address adder, handshake, and termination compare.

Test Plan:
1. Up, sew=10, lmul=1, bases 0 and 64, slide 0, el_count 16, ready=1: 16 beats; addr 0..7 then 64..71; last_o on addr 71; done_o one cycle later.
2. Down, same config: addr 71..64 then 7..0; byte_sel_o=00 throughout; last_o on addr 0.
3. sew=00, lmul=0, base 10, el_count 6: addr 10,10,10,10,11,11; byte_sel_o 0,1,2,3,0,1.
4. Backpressure: case 1 with ready_i low on cycles 3-5: valid_o held with addr 2 stable; the sequence resumes unchanged; 16 beats total.
5. Wrap and clip: base 508, slide 6, sew=10, lmul=0, el_count 20: addr 2..9 (8 beats, clipped); done_o follows.
6. Edge cases:
   - el_count 0: done_o at T+1 with no valid_o.
   - sew=11: err_o and done_o at T+1.
   - rst_i mid-RUN: valid_o=0 next cycle and no done_o.
   - start_i during RUN: ignored.
